// File: rtl/wired_mdu_arb_pkg.sv
// wired_mdu_arb_pkg: shared MDU request/response types and arbiter defaults
package wired_mdu_arb_pkg;
  localparam int MDU_ARB_DEPTH = 4;
  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic [7:0]  tag;
  } iq_mdu_req_t;
  typedef struct packed {
    logic [31:0] result;
    logic [7:0]  tag;
  } iq_mdu_resp_t;
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/wired_mdu_arb_if.sv
// wired_mdu_arb_if: requester, execution-unit and response handshakes of the MDU arbiter
// slave modport is the arbiter view; master modport is the surrounding pipeline / execution unit.
// Signals: flush_i, req_valid_i/req_ready_o/req_i, ex_valid_o/ex_ready_i/ex_req_o,
// ex_valid_i/ex_ready_o/ex_resp_i, resp_valid_o/resp_ready_i/resp_o.
interface wired_mdu_arb_if import wired_mdu_arb_pkg::*; #(parameter int REQ_CNT = 2);
  logic                                flush_i;
  logic [REQ_CNT-1:0]                  req_valid_i;
  logic [REQ_CNT-1:0]                  req_ready_o;
  iq_mdu_req_t [REQ_CNT-1:0]           req_i;
  logic                                ex_valid_o;
  logic                                ex_ready_i;
  iq_mdu_req_t                         ex_req_o;
  logic                                ex_valid_i;
  logic                                ex_ready_o;
  iq_mdu_resp_t                        ex_resp_i;
  logic [REQ_CNT-1:0]                  resp_valid_o;
  logic [REQ_CNT-1:0]                  resp_ready_i;
  iq_mdu_resp_t                        resp_o;
  modport slave (
    input  flush_i, req_valid_i, req_i, ex_ready_i, ex_valid_i, ex_resp_i, resp_ready_i,
    output req_ready_o, ex_valid_o, ex_req_o, ex_ready_o, resp_valid_o, resp_o
  );
  modport master (
    output flush_i, req_valid_i, req_i, ex_ready_i, ex_valid_i, ex_resp_i, resp_ready_i,
    input  req_ready_o, ex_valid_o, ex_req_o, ex_ready_o, resp_valid_o, resp_o
  );
endinterface

// File: rtl/wired_mdu_owner_fifo.sv
// wired_mdu_owner_fifo: in-order FIFO of requester indices owning in-flight MDU operations
// Ports: clk, rst (async high), flush (clears next cycle), push/push_data, pop, count, head_data.
module wired_mdu_owner_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [$clog2(DEPTH):0]   count,
  output logic [W-1:0]             head_data
);
  localparam int AW = $clog2(DEPTH);
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [AW:0]   count_q, count_d;
  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[tail_q] = push_data;
    head_d  = flush ? '0 : head_q + AW'(pop);
    tail_d  = flush ? '0 : tail_q + AW'(push);
    count_d = flush ? '0 : count_q + (AW+1)'(push) - (AW+1)'(pop);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      mem_q   <= '{default: '0};
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      mem_q   <= mem_d;
    end
  end
  assign count     = count_q;
  assign head_data = mem_q[head_q];
endmodule

// File: rtl/wired_mdu_arb.sv
// wired_mdu_arb: round-robin arbiter sharing one in-order MDU among REQ_CNT issue queues
// Ports: clk, rst (async high), bus (wired_mdu_arb_if.slave) carrying flush, request,
// execution-unit and response handshakes.
// Optional WIRED_MDU_ARB_RESP_REG_EN: one-entry registered response buffer (+1 cycle latency).
module wired_mdu_arb import wired_mdu_arb_pkg::*; #(
  parameter int REQ_CNT = 2,
  parameter int DEPTH   = MDU_ARB_DEPTH
) (
  input logic             clk,
  input logic             rst,
  wired_mdu_arb_if.slave  bus
);
  localparam int IW = idx_w(REQ_CNT);
  localparam int CW = $clog2(DEPTH) + 1;
  logic [IW-1:0] rr_q, rr_d, hold_idx_q, hold_idx_d, pick, idx, sel, head;
  logic          hold_q, hold_d, push, pop, full, empty;
  logic [CW-1:0] count;
  wired_mdu_owner_fifo #(.DEPTH(DEPTH), .W(IW)) u_fifo (
    .clk(clk), .rst(rst), .flush(bus.flush_i), .push(push), .push_data(sel),
    .pop(pop), .count(count), .head_data(head)
  );
  assign full  = count == CW'(DEPTH);
  assign empty = count == '0;
  // Scan descending so the requester closest after rr_q is the last (winning) assignment.
  // A stalled offer keeps its grant so ex_req_o cannot change under backpressure.
  always_comb begin
    pick = rr_q;
    idx  = '0;
    for (int k = REQ_CNT - 1; k >= 0; k--) begin
      idx = IW'((int'(rr_q) + k) % REQ_CNT);
      if (bus.req_valid_i[idx]) pick = idx;
    end
    sel = (hold_q && bus.req_valid_i[hold_idx_q]) ? hold_idx_q : pick;
    bus.ex_valid_o  = !rst && !bus.flush_i && !full && |bus.req_valid_i;
    push            = bus.ex_valid_o && bus.ex_ready_i;
    bus.req_ready_o = push ? (REQ_CNT'(1) << sel) : '0;
    bus.ex_req_o    = bus.req_i[sel];
    hold_d          = bus.ex_valid_o && !bus.ex_ready_i;
    hold_idx_d      = sel;
    rr_d            = push ? ((sel == IW'(REQ_CNT - 1)) ? '0 : sel + 1'b1) : rr_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q       <= '0;
      hold_q     <= 1'b0;
      hold_idx_q <= '0;
    end else begin
      rr_q       <= rr_d;
      hold_q     <= hold_d;
      hold_idx_q <= hold_idx_d;
    end
  end
`ifdef WIRED_MDU_ARB_RESP_REG_EN
  logic          buf_v_q, buf_v_d, load, drain;
  iq_mdu_resp_t  buf_q, buf_d;
  logic [IW-1:0] buf_own_q, buf_own_d;
  // Ownership leaves the FIFO when the response enters the buffer, not when it is drained.
  always_comb begin
    drain            = buf_v_q && bus.resp_ready_i[buf_own_q];
    bus.ex_ready_o   = !rst && (bus.flush_i || empty || !buf_v_q || drain);
    load             = bus.ex_valid_i && bus.ex_ready_o && !empty && !bus.flush_i;
    pop              = load;
    buf_v_d          = !bus.flush_i && (load || (buf_v_q && !drain));
    buf_d            = load ? bus.ex_resp_i : buf_q;
    buf_own_d        = load ? head : buf_own_q;
    bus.resp_valid_o = buf_v_q ? (REQ_CNT'(1) << buf_own_q) : '0;
    bus.resp_o       = buf_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_v_q   <= 1'b0;
      buf_q     <= '0;
      buf_own_q <= '0;
    end else begin
      buf_v_q   <= buf_v_d;
      buf_q     <= buf_d;
      buf_own_q <= buf_own_d;
    end
  end
`else
  // Responses with no owner (empty FIFO or flush) are accepted and dropped.
  always_comb begin
    bus.ex_ready_o   = !rst && (bus.flush_i || empty || bus.resp_ready_i[head]);
    pop              = bus.ex_valid_i && bus.ex_ready_o && !empty && !bus.flush_i;
    bus.resp_valid_o = (rst || bus.flush_i || empty || !bus.ex_valid_i) ? '0 : (REQ_CNT'(1) << head);
    bus.resp_o       = bus.ex_resp_i;
  end
`endif
endmodule

// File: tb/tb_wired_mdu_arb.sv
// tb_wired_mdu_arb: directed and randomized self-checking bench for wired_mdu_arb
module tb_wired_mdu_arb;
  import wired_mdu_arb_pkg::*;
  localparam int N = 2;
  localparam int D = 4;
  logic clk = 1'b0;
  logic rst;
  int total = 0;
  int bad = 0;
  wired_mdu_arb_if #(.REQ_CNT(N)) bus();
  wired_mdu_arb #(.REQ_CNT(N), .DEPTH(D)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
  function automatic iq_mdu_req_t mk_req(input logic [7:0] tag);
    iq_mdu_req_t r;
    r.op = 4'($urandom);
    r.src_a = $urandom;
    r.src_b = $urandom;
    r.tag = tag;
    return r;
  endfunction
  function automatic iq_mdu_resp_t mk_resp(input logic [7:0] tag);
    iq_mdu_resp_t r;
    r.result = $urandom;
    r.tag = tag;
    return r;
  endfunction
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask
  task automatic idle;
    bus.flush_i = 1'b0;
    bus.req_valid_i = '0;
    bus.req_i = '0;
    bus.ex_ready_i = 1'b0;
    bus.ex_valid_i = 1'b0;
    bus.ex_resp_i = '0;
    bus.resp_ready_i = '0;
  endtask
  task automatic do_reset;
    rst = 1'b1;
    idle();
    cyc();
    cyc();
    rst = 1'b0;
  endtask
  task automatic test_reset;
    rst = 1'b1;
    bus.req_valid_i = 2'b11;
    bus.ex_ready_i = 1'b1;
    bus.ex_valid_i = 1'b1;
    bus.resp_ready_i = 2'b11;
    #1;
    total++; if (bus.req_ready_o !== 2'b00) begin bad++; $display("FAIL rst_req_ready: got %b want 00", bus.req_ready_o); end
    total++; if (bus.ex_valid_o !== 1'b0) begin bad++; $display("FAIL rst_ex_valid: got %b want 0", bus.ex_valid_o); end
    total++; if (bus.resp_valid_o !== 2'b00) begin bad++; $display("FAIL rst_resp_valid: got %b want 00", bus.resp_valid_o); end
    total++; if (bus.ex_ready_o !== 1'b0) begin bad++; $display("FAIL rst_ex_ready: got %b want 0", bus.ex_ready_o); end
    cyc();
    total++; if (bus.ex_valid_o !== 1'b0) begin bad++; $display("FAIL rst_ex_valid_clk: got %b want 0", bus.ex_valid_o); end
  endtask
  task automatic test_round_robin;
    iq_mdu_req_t rq [N];
    iq_mdu_resp_t rs;
    logic [1:0] exp;
    do_reset();
    rq[0] = mk_req(8'h10);
    rq[1] = mk_req(8'h21);
    bus.req_i[0] = rq[0];
    bus.req_i[1] = rq[1];
    bus.req_valid_i = 2'b11;
    bus.ex_ready_i = 1'b1;
    bus.resp_ready_i = 2'b11;
    for (int k = 0; k < 6; k++) begin
      rs = mk_resp(8'(k));
      bus.ex_valid_i = (k > 0);
      bus.ex_resp_i = rs;
      #1;
      exp = (k % 2 == 0) ? 2'b01 : 2'b10;
      total++; if (bus.req_ready_o !== exp) begin bad++; $display("FAIL rr_grant[%0d]: got %b want %b", k, bus.req_ready_o, exp); end
      total++; if (bus.ex_req_o !== rq[k % 2]) begin bad++; $display("FAIL rr_ex_req[%0d]: got %h want %h", k, bus.ex_req_o, rq[k % 2]); end
`ifndef WIRED_MDU_ARB_RESP_REG_EN
      if (k > 0) begin
        exp = (k % 2 == 1) ? 2'b01 : 2'b10;
        total++; if (bus.resp_valid_o !== exp) begin bad++; $display("FAIL rr_resp_route[%0d]: got %b want %b", k, bus.resp_valid_o, exp); end
        total++; if (bus.resp_o !== rs) begin bad++; $display("FAIL rr_resp_data[%0d]: got %h want %h", k, bus.resp_o, rs); end
      end
`endif
      cyc();
    end
  endtask
  task automatic test_full;
    do_reset();
    bus.req_i[0] = mk_req(8'h33);
    bus.req_valid_i = 2'b01;
    bus.ex_ready_i = 1'b1;
    for (int k = 0; k < D; k++) begin
      #1;
      total++; if (bus.ex_valid_o !== 1'b1) begin bad++; $display("FAIL full_issue[%0d]: got %b want 1", k, bus.ex_valid_o); end
      cyc();
    end
    #1;
    total++; if (bus.ex_valid_o !== 1'b0) begin bad++; $display("FAIL full_block: got %b want 0", bus.ex_valid_o); end
    total++; if (bus.req_ready_o !== 2'b00) begin bad++; $display("FAIL full_block_ready: got %b want 00", bus.req_ready_o); end
    cyc();
    bus.ex_valid_i = 1'b1;
    bus.ex_resp_i = mk_resp(8'h01);
    bus.resp_ready_i = 2'b01;
    #1;
    total++; if (bus.ex_valid_o !== 1'b0) begin bad++; $display("FAIL full_block_on_pop: got %b want 0", bus.ex_valid_o); end
    total++; if (bus.ex_ready_o !== 1'b1) begin bad++; $display("FAIL full_pop_ready: got %b want 1", bus.ex_ready_o); end
    cyc();
    bus.ex_valid_i = 1'b0;
    #1;
    total++; if (bus.ex_valid_o !== 1'b1) begin bad++; $display("FAIL full_release: got %b want 1", bus.ex_valid_o); end
    cyc();
  endtask
  task automatic test_stall_hold;
    iq_mdu_req_t rq [N];
    do_reset();
    rq[0] = mk_req(8'h40);
    rq[1] = mk_req(8'h41);
    bus.req_i[0] = rq[0];
    bus.req_i[1] = rq[1];
    bus.req_valid_i = 2'b01;
    bus.ex_ready_i = 1'b1;
    #1;
    total++; if (bus.req_ready_o !== 2'b01) begin bad++; $display("FAIL hold_first: got %b want 01", bus.req_ready_o); end
    cyc();
    bus.ex_ready_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) bus.req_valid_i = 2'b11;
      #1;
      total++; if (bus.ex_valid_o !== 1'b1) begin bad++; $display("FAIL hold_valid[%0d]: got %b want 1", k, bus.ex_valid_o); end
      total++; if (bus.req_ready_o !== 2'b00) begin bad++; $display("FAIL hold_ready[%0d]: got %b want 00", k, bus.req_ready_o); end
      total++; if (bus.ex_req_o !== rq[0]) begin bad++; $display("FAIL hold_req[%0d]: got %h want %h", k, bus.ex_req_o, rq[0]); end
      cyc();
    end
    bus.ex_ready_i = 1'b1;
    #1;
    total++; if (bus.req_ready_o !== 2'b01) begin bad++; $display("FAIL hold_release: got %b want 01", bus.req_ready_o); end
    cyc();
    #1;
    total++; if (bus.req_ready_o !== 2'b10) begin bad++; $display("FAIL hold_rr_next: got %b want 10", bus.req_ready_o); end
    cyc();
  endtask
  task automatic test_flush;
    do_reset();
    bus.req_i[0] = mk_req(8'h50);
    bus.req_valid_i = 2'b01;
    bus.ex_ready_i = 1'b1;
    cyc();
    cyc();
    bus.flush_i = 1'b1;
    bus.ex_valid_i = 1'b1;
    bus.ex_resp_i = mk_resp(8'h51);
    bus.resp_ready_i = 2'b00;
    #1;
    total++; if (bus.ex_valid_o !== 1'b0) begin bad++; $display("FAIL flush_block: got %b want 0", bus.ex_valid_o); end
    total++; if (bus.req_ready_o !== 2'b00) begin bad++; $display("FAIL flush_ready: got %b want 00", bus.req_ready_o); end
    total++; if (bus.resp_valid_o !== 2'b00) begin bad++; $display("FAIL flush_drop: got %b want 00", bus.resp_valid_o); end
    total++; if (bus.ex_ready_o !== 1'b1) begin bad++; $display("FAIL flush_consume: got %b want 1", bus.ex_ready_o); end
    cyc();
    bus.flush_i = 1'b0;
    bus.req_valid_i = 2'b00;
    #1;
    total++; if (bus.resp_valid_o !== 2'b00) begin bad++; $display("FAIL late_resp: got %b want 00", bus.resp_valid_o); end
    total++; if (bus.ex_ready_o !== 1'b1) begin bad++; $display("FAIL late_consume: got %b want 1", bus.ex_ready_o); end
    cyc();
    bus.ex_valid_i = 1'b0;
    bus.req_valid_i = 2'b01;
    for (int k = 0; k < D; k++) begin
      #1;
      total++; if (bus.ex_valid_o !== 1'b1) begin bad++; $display("FAIL post_flush_issue[%0d]: got %b want 1", k, bus.ex_valid_o); end
      cyc();
    end
    #1;
    total++; if (bus.ex_valid_o !== 1'b0) begin bad++; $display("FAIL post_flush_full: got %b want 0", bus.ex_valid_o); end
    cyc();
  endtask
`ifdef WIRED_MDU_ARB_RESP_REG_EN
  task automatic test_resp_reg;
    iq_mdu_resp_t rs;
    do_reset();
    bus.req_i[1] = mk_req(8'h60);
    bus.req_valid_i = 2'b10;
    bus.ex_ready_i = 1'b1;
    cyc();
    bus.req_valid_i = 2'b00;
    rs = mk_resp(8'h61);
    bus.ex_resp_i = rs;
    bus.ex_valid_i = 1'b1;
    bus.resp_ready_i = 2'b10;
    #1;
    total++; if (bus.resp_valid_o !== 2'b00) begin bad++; $display("FAIL reg_same_cycle: got %b want 00", bus.resp_valid_o); end
    total++; if (bus.ex_ready_o !== 1'b1) begin bad++; $display("FAIL reg_accept: got %b want 1", bus.ex_ready_o); end
    cyc();
    bus.ex_valid_i = 1'b0;
    #1;
    total++; if (bus.resp_valid_o !== 2'b10) begin bad++; $display("FAIL reg_next_cycle: got %b want 10", bus.resp_valid_o); end
    total++; if (bus.resp_o !== rs) begin bad++; $display("FAIL reg_data: got %h want %h", bus.resp_o, rs); end
    cyc();
    #1;
    total++; if (bus.resp_valid_o !== 2'b00) begin bad++; $display("FAIL reg_drained: got %b want 00", bus.resp_valid_o); end
    bus.req_valid_i = 2'b10;
    cyc();
    bus.req_valid_i = 2'b00;
    bus.ex_valid_i = 1'b1;
    bus.resp_ready_i = 2'b00;
    cyc();
    bus.ex_valid_i = 1'b0;
    bus.flush_i = 1'b1;
    #1;
    total++; if (bus.resp_valid_o !== 2'b10) begin bad++; $display("FAIL reg_held: got %b want 10", bus.resp_valid_o); end
    cyc();
    bus.flush_i = 1'b0;
    #1;
    total++; if (bus.resp_valid_o !== 2'b00) begin bad++; $display("FAIL reg_flush_clear: got %b want 00", bus.resp_valid_o); end
    cyc();
  endtask
`else
  task automatic test_resp_backpressure;
    iq_mdu_resp_t rs;
    do_reset();
    bus.req_i[1] = mk_req(8'h70);
    bus.req_valid_i = 2'b10;
    bus.ex_ready_i = 1'b1;
    #1;
    total++; if (bus.req_ready_o !== 2'b10) begin bad++; $display("FAIL bp_issue: got %b want 10", bus.req_ready_o); end
    cyc();
    bus.req_valid_i = 2'b00;
    rs = mk_resp(8'h55);
    bus.ex_resp_i = rs;
    bus.ex_valid_i = 1'b1;
    bus.resp_ready_i = 2'b00;
    for (int k = 0; k < 2; k++) begin
      #1;
      total++; if (bus.ex_ready_o !== 1'b0) begin bad++; $display("FAIL bp_stall[%0d]: got %b want 0", k, bus.ex_ready_o); end
      total++; if (bus.resp_valid_o !== 2'b10) begin bad++; $display("FAIL bp_valid[%0d]: got %b want 10", k, bus.resp_valid_o); end
      total++; if (bus.resp_o !== rs) begin bad++; $display("FAIL bp_data[%0d]: got %h want %h", k, bus.resp_o, rs); end
      cyc();
    end
    bus.resp_ready_i = 2'b10;
    #1;
    total++; if (bus.ex_ready_o !== 1'b1) begin bad++; $display("FAIL bp_accept: got %b want 1", bus.ex_ready_o); end
    cyc();
    bus.resp_ready_i = 2'b00;
    #1;
    total++; if (bus.resp_valid_o !== 2'b00) begin bad++; $display("FAIL bp_popped: got %b want 00", bus.resp_valid_o); end
    total++; if (bus.ex_ready_o !== 1'b1) begin bad++; $display("FAIL bp_empty_drop: got %b want 1", bus.ex_ready_o); end
    cyc();
  endtask
  task automatic test_random;
    int q[$];
    int rr;
    int hidx;
    int pick;
    int own;
    bit hold;
    bit fl;
    bit er;
    bit evi;
    bit exp_ev;
    bit exp_er;
    logic [1:0] rv;
    logic [1:0] rdy;
    logic [1:0] exp_rr;
    logic [1:0] exp_rv;
    iq_mdu_req_t rq [N];
    iq_mdu_resp_t rs;
    do_reset();
    rr = 0;
    hold = 0;
    hidx = 0;
    for (int i = 0; i < N; i++) rq[i] = mk_req(8'(i));
    for (int c = 0; c < 600; c++) begin
      rv = 2'($urandom);
      if (hold) rv[hidx] = 1'b1;
      for (int i = 0; i < N; i++) if (!(hold && i == hidx)) rq[i] = mk_req(8'($urandom));
      for (int i = 0; i < N; i++) bus.req_i[i] = rq[i];
      er = $urandom_range(0, 3) != 0;
      fl = $urandom_range(0, 31) == 0;
      evi = 1'($urandom);
      rdy = 2'($urandom);
      rs = mk_resp(8'($urandom));
      bus.req_valid_i = rv;
      bus.ex_ready_i = er;
      bus.flush_i = fl;
      bus.ex_valid_i = evi;
      bus.resp_ready_i = rdy;
      bus.ex_resp_i = rs;
      #1;
      exp_ev = (rv != 2'b00) && (q.size() < D) && !fl;
      pick = hidx;
      if (!hold) begin
        pick = -1;
        for (int k = 0; k < N; k++) if (pick < 0 && rv[(rr + k) % N]) pick = (rr + k) % N;
        if (pick < 0) pick = 0;
      end
      exp_rr = (exp_ev && er) ? 2'(1 << pick) : 2'b00;
      total++; if (bus.ex_valid_o !== exp_ev) begin bad++; $display("FAIL rnd_ex_valid[%0d]: got %b want %b", c, bus.ex_valid_o, exp_ev); end
      total++; if (bus.req_ready_o !== exp_rr) begin bad++; $display("FAIL rnd_req_ready[%0d]: got %b want %b", c, bus.req_ready_o, exp_rr); end
      if (exp_ev) begin
        total++; if (bus.ex_req_o !== rq[pick]) begin bad++; $display("FAIL rnd_ex_req[%0d]: got %h want %h", c, bus.ex_req_o, rq[pick]); end
      end
      own = 0;
      if (fl || q.size() == 0) begin
        exp_rv = 2'b00;
        exp_er = 1'b1;
      end else begin
        own = q[0];
        exp_rv = evi ? 2'(1 << own) : 2'b00;
        exp_er = rdy[own];
      end
      total++; if (bus.resp_valid_o !== exp_rv) begin bad++; $display("FAIL rnd_resp_valid[%0d]: got %b want %b", c, bus.resp_valid_o, exp_rv); end
      total++; if (bus.ex_ready_o !== exp_er) begin bad++; $display("FAIL rnd_ex_ready[%0d]: got %b want %b", c, bus.ex_ready_o, exp_er); end
      if (exp_rv != 2'b00) begin
        total++; if (bus.resp_o !== rs) begin bad++; $display("FAIL rnd_resp_data[%0d]: got %h want %h", c, bus.resp_o, rs); end
      end
      if (fl) q.delete();
      else begin
        if (q.size() > 0 && evi && exp_er) void'(q.pop_front());
        if (exp_ev && er) begin
          q.push_back(pick);
          rr = (pick + 1) % N;
        end
      end
      hold = exp_ev && !er;
      hidx = pick;
      cyc();
    end
  endtask
`endif
  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_round_robin();
    test_full();
    test_stall_hold();
    test_flush();
`ifdef WIRED_MDU_ARB_RESP_REG_EN
    test_resp_reg();
`else
    test_resp_backpressure();
    test_random();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/wired_mdu_arb.md
WIRED_MDU_ARB -- requirements
Module: wired_mdu_arb

Interface
REQ-001 Parameter REQ_CNT, default 2: number of IQ requesters sharing one MDU execution unit.
REQ-002 Parameter DEPTH, default 4: maximum in-flight operations (owner FIFO entries); power of two, >= 2.
REQ-003 clk  input  1  sole clock; all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 flush_i  input  1  pipeline flush from commit.
REQ-006 req_valid_i  input  REQ_CNT  per-requester operation valid.
REQ-007 req_ready_o  output  REQ_CNT  per-requester accept.
REQ-008 req_i  input  REQ_CNT x iq_mdu_req_t  per-requester operation.
REQ-009 ex_valid_o / ex_ready_i / ex_req_o  output / input / output  1 / 1 / iq_mdu_req_t  request to execution unit.
REQ-010 ex_valid_i / ex_ready_o / ex_resp_i  input / output / input  1 / 1 / iq_mdu_resp_t  response from execution unit.
REQ-011 resp_valid_o  output  REQ_CNT  per-requester response valid.
REQ-012 resp_ready_i  input  REQ_CNT  per-requester response accept.
REQ-013 resp_o  output  iq_mdu_resp_t  response payload, shared by all requesters.

Function
REQ-014 Grant SHALL be round-robin: priority starts at requester after last granted; pointer advances only on an ex handshake.
REQ-015 While ex_valid_o=1 and ex_ready_i=0, the grant and ex_req_o SHALL hold; no re-arbitration.
REQ-016 req_ready_o[i] SHALL equal granted[i] & ex_ready_i & !full & !flush_i; ex_valid_o = any req_valid & !full & !flush_i.
REQ-017 On an ex handshake, the granted index SHALL be pushed into the owner FIFO; request latency through arbiter is 0 cycles (combinational).
REQ-018 Full when count==DEPTH: SHALL block new issue even if a pop occurs the same cycle.
REQ-019 Response SHALL route to the FIFO-head owner: resp_valid_o[head]=ex_valid_i, ex_ready_o=resp_ready_i[head]; FIFO pops on that handshake.
REQ-020 Simultaneous push and pop SHALL keep count unchanged; pointers wrap modulo DEPTH.
REQ-021 ex_valid_i with empty FIFO SHALL be consumed (ex_ready_o=1) and dropped, never forwarded.
REQ-022 flush_i SHALL clear FIFO (count=0, pointers=0) next cycle and drop any same-cycle response; round-robin pointer retained.
REQ-023 Execution unit is in order; FIFO order equals response order.

Reset
REQ-024 During rst: count, head, tail, round-robin pointer = 0; req_ready_o=0, ex_valid_o=0, resp_valid_o=0, ex_ready_o=0 (empty-drop disabled while rst asserted).
REQ-025 rst asserted mid-operation SHALL discard all in-flight ownership immediately (asynchronous).

Configuration
REQ-026 Macro WIRED_MDU_ARB_RESP_REG_EN defined: one-entry registered response buffer (valid+payload+owner), +1 cycle response latency, ex_ready_o = buffer empty or being drained; undefined: combinational pass-through per REQ-019.
REQ-027 With macro, flush_i and rst SHALL clear the buffer valid.

Structure
REQ-028 iq_mdu_req_t, iq_mdu_resp_t and MDU_ARB default DEPTH constant SHALL live in the shared wired package.
REQ-029 Owner FIFO SHALL be a sub-module wired_mdu_owner_fifo (push/pop/flush, count, head data); arbitration in top module.

Verification
REQ-030 req_valid_i=2'b11 continuously, ex_ready_i=1, responses returned 1 cycle later -> grants alternate 0,1,0,1; responses to 0,1,0,1.
REQ-031 Four ops issued, no responses, DEPTH=4 -> fifth blocked (ex_valid_o=0) until first response handshake plus one cycle.
REQ-032 ex_ready_i=0 for 3 cycles with req_valid_i=2'b01 then 2'b11 -> ex_req_o stable, grant stays 0.
REQ-033 Two ops in flight, flush_i pulsed -> count 0 next cycle; late ex_valid_i consumed, resp_valid_o stays 0.
REQ-034 resp_ready_i[owner]=0 for 2 cycles -> ex_ready_o=0, FIFO not popped, resp_o stable.
REQ-035 With WIRED_MDU_ARB_RESP_REG_EN: response at cycle N appears on resp_valid_o at N+1; flush at N clears it.
